// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into a burst-write master: one command per burst,
// full BLEN bursts by occupancy threshold, partial final burst on flush.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RANGE = 2,
  parameter int unsigned BLEN  = 4,
  parameter int unsigned AW    = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_empty,
  input  logic [WIDTH-1:0] i_dt,
  input  logic [RANGE:0]   i_dnum,
  output logic             o_renable,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base_adrs,
  input  logic             i_flush,
  output logic             o_req,
  output logic [AW-1:0]    o_adrs,
  output logic [RANGE:0]   o_blen,
  input  logic             i_ack,
  output logic             o_wvalid,
  output logic [WIDTH-1:0] o_wdata,
  input  logic             i_wack,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_wcount
);

  localparam int unsigned CW = RANGE + 1;
  localparam logic [CW-1:0] BLEN_C = CW'(BLEN);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMD, S_DATA, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   adrs_q, adrs_d;
  logic [CW-1:0]   blen_q, blen_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [15:0]     wcount_q, wcount_d;
  logic            req_q, req_d;
  logic            wvalid_q, wvalid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    adrs_d   = adrs_q;
    blen_d   = blen_q;
    beat_d   = beat_q;
    wcount_d = wcount_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d   = i_base_adrs;
          wcount_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Threshold wins over flush; a zero count never yields a burst
        if (i_dnum >= BLEN_C) begin
          adrs_d  = addr_q;
          blen_d  = BLEN_C;
          state_d = S_CMD;
        end else if (i_flush && !i_empty && (i_dnum != '0)) begin
          adrs_d  = addr_q;
          blen_d  = i_dnum;
          state_d = S_CMD;
        end else if (i_flush && i_empty) begin
          state_d = S_DONE;
        end
      end
      S_CMD: begin
        if (i_ack) begin
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_wack) begin
          beat_d   = beat_q + CW'(1);
          wcount_d = wcount_q + 16'd1;
          if (beat_q == blen_q - CW'(1)) begin
            addr_d  = addr_q + AW'(blen_q);
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d    = (state_d == S_CMD);
    wvalid_d = (state_d == S_DATA);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      adrs_q   <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      wcount_q <= '0;
      req_q    <= 1'b0;
      wvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      adrs_q   <= adrs_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      wcount_q <= wcount_d;
      req_q    <= req_d;
      wvalid_q <= wvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Data path is zero-latency: the FIFO head goes straight out and pops on acceptance
  assign o_renable = wvalid_q & i_wack & ~i_empty;
  assign o_wdata   = i_dt;
  assign o_wvalid  = wvalid_q;
  assign o_req     = req_q;
  assign o_adrs    = adrs_q;
  assign o_blen    = blen_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_wcount  = wcount_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: queue-based FIFO and transaction-level
// scoreboard of commands, beats, addresses and completion.
module tb_fifo_burst_reader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned RANGE = 2;
  localparam int unsigned BLEN  = 4;
  localparam int unsigned AW    = 30;
  localparam int unsigned CW    = RANGE + 1;
  localparam int          DEPTH = 1 << RANGE;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_empty;
  logic [WIDTH-1:0] i_dt;
  logic [RANGE:0]   i_dnum;
  logic             o_renable;
  logic             i_start;
  logic [AW-1:0]    i_base_adrs;
  logic             i_flush;
  logic             o_req;
  logic [AW-1:0]    o_adrs;
  logic [RANGE:0]   o_blen;
  logic             i_ack;
  logic             o_wvalid;
  logic [WIDTH-1:0] o_wdata;
  logic             i_wack;
  logic             o_busy;
  logic             o_done;
  logic [15:0]      o_wcount;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .RANGE(RANGE), .BLEN(BLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_empty(i_empty), .i_dt(i_dt), .i_dnum(i_dnum),
    .o_renable(o_renable), .i_start(i_start), .i_base_adrs(i_base_adrs),
    .i_flush(i_flush), .o_req(o_req), .o_adrs(o_adrs), .o_blen(o_blen),
    .i_ack(i_ack), .o_wvalid(o_wvalid), .o_wdata(o_wdata), .i_wack(i_wack),
    .o_busy(o_busy), .o_done(o_done), .o_wcount(o_wcount)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO contents and words still waiting to be pushed
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] pend_q[$];
  bit               pop_pend = 1'b0;

  // Stimulus controls
  int            wack_mode = 0;
  int            ack_mode  = 0;
  bit            flush_en  = 1'b0;
  bit            start_now = 1'b0;
  bit            start_noise = 1'b0;
  bit            tog = 1'b0;
  logic [AW-1:0] start_base = '0;

  // Scoreboard state
  logic [AW-1:0] exp_adrs = '0;
  logic [AW-1:0] req_adrs = '0;
  logic [CW-1:0] req_blen = '0;
  int            remaining = 0;
  int            exp_wcount = 0;
  int            beats_left = 0;
  int            pops = 0;
  int            dones = 0;
  bit            in_data = 1'b0;
  bit            req_wait = 1'b0;
  bit            done_prev = 1'b0;

  task automatic cycle();
    logic [CW-1:0] eb;
    bit            next_data;
    @(negedge clk);
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    if (pend_q.size() > 0 && fifo_q.size() < DEPTH) fifo_q.push_back(pend_q.pop_front());
    i_dnum  = CW'(fifo_q.size());
    i_empty = (fifo_q.size() == 0);
    i_dt    = i_empty ? WIDTH'($urandom) : fifo_q[0];
    tog     = ~tog;
    case (wack_mode)
      0:       i_wack = 1'b1;
      1:       i_wack = tog;
      default: i_wack = 1'($urandom % 2);
    endcase
    i_ack       = (ack_mode == 0) ? 1'b1 : 1'($urandom % 2);
    i_flush     = flush_en && (pend_q.size() == 0);
    i_start     = start_now || (start_noise && ($urandom % 16 == 0));
    i_base_adrs = start_now ? start_base : AW'($urandom);
    #1;

    if (o_wvalid) chk("wdata_passthru", 64'(o_wdata), 64'(i_dt));
    chk("wvalid", 64'(o_wvalid), 64'(in_data));
    chk("renable", 64'(o_renable), 64'(in_data && i_wack && !i_empty));
    chk("wcount", 64'(o_wcount), 64'(exp_wcount[15:0]));
    if (req_wait) chk("req_hold", 64'(o_req), 64'(1));
    if (o_req) begin
      if (!req_wait) begin
        eb = (remaining >= int'(BLEN)) ? CW'(BLEN) : CW'(remaining);
        chk("cmd_adrs", 64'(o_adrs), 64'(exp_adrs));
        chk("cmd_blen", 64'(o_blen), 64'(eb));
        req_adrs = exp_adrs;
        req_blen = eb;
      end else begin
        chk("adrs_hold", 64'(o_adrs), 64'(req_adrs));
        chk("blen_hold", 64'(o_blen), 64'(req_blen));
      end
    end

    next_data = in_data;
    if (in_data && i_wack) begin
      chk("beat_fifo_nonempty", 64'(i_empty), 64'(0));
      if (fifo_q.size() > 0) chk("beat_wdata", 64'(o_wdata), 64'(fifo_q[0]));
      exp_wcount++;
      remaining--;
      beats_left--;
      if (beats_left == 0) begin
        next_data = 1'b0;
        exp_adrs  = exp_adrs + AW'(req_blen);
      end
    end
    if (o_req && i_ack) begin
      next_data  = 1'b1;
      beats_left = int'(req_blen);
    end
    if (o_renable) pops++;
    pop_pend = o_renable;

    if (done_prev) chk("busy_after_done", 64'(o_busy), 64'(0));
    if (o_done) begin
      dones++;
      chk("done_remaining", 64'(remaining), 64'(0));
      chk("done_busy", 64'(o_busy), 64'(1));
      start_noise = 1'b0;
    end
    done_prev = o_done;
    in_data   = next_data;
    req_wait  = o_req && !i_ack;
  endtask

  task automatic begin_xfer(input logic [AW-1:0] base, input int n, input int wm,
                            input int am, input bit fl);
    pend_q.delete();
    for (int i = 0; i < n; i++) pend_q.push_back(WIDTH'($urandom));
    wack_mode   = wm;
    ack_mode    = am;
    flush_en    = fl;
    tog         = 1'b0;
    pops        = 0;
    dones       = 0;
    remaining   = n;
    exp_adrs    = base;
    start_base  = base;
    start_noise = 1'b0;
    start_now   = 1'b1;
    cycle();
    start_now  = 1'b0;
    exp_wcount = 0;
    cycle();
    chk("busy_after_start", 64'(o_busy), 64'(1));
  endtask

  task automatic run_xfer(input logic [AW-1:0] base, input int n, input int wm,
                          input int am, input bit noise);
    int guard;
    begin_xfer(base, n, wm, am, 1'b1);
    start_noise = noise;
    guard = 0;
    while (dones == 0 && guard < 3000) begin
      cycle();
      guard++;
    end
    chk("xfer_done_seen", 64'(dones), 64'(1));
    cycle();
    cycle();
    chk("final_wcount", 64'(o_wcount), 64'(n[15:0]));
    chk("final_pops", 64'(pops), 64'(n));
    chk("done_pulses", 64'(dones), 64'(1));
    flush_en = 1'b0;
  endtask

  task automatic chk_outputs_zero();
    chk("rst_req", 64'(o_req), 64'(0));
    chk("rst_wvalid", 64'(o_wvalid), 64'(0));
    chk("rst_renable", 64'(o_renable), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_adrs", 64'(o_adrs), 64'(0));
    chk("rst_blen", 64'(o_blen), 64'(0));
    chk("rst_wcount", 64'(o_wcount), 64'(0));
  endtask

  task automatic mid_burst_reset();
    int guard;
    begin_xfer(AW'(32'h500), 4, 0, 0, 1'b0);
    guard = 0;
    while (o_wcount != 16'd2 && guard < 200) begin
      cycle();
      guard++;
    end
    chk("mid_two_beats", 64'(o_wcount), 64'(2));
    #1 rst = 1'b1;
    #1 chk_outputs_zero();
    fifo_q.delete();
    pend_q.delete();
    pop_pend   = 1'b0;
    in_data    = 1'b0;
    req_wait   = 1'b0;
    done_prev  = 1'b0;
    exp_wcount = 0;
    @(negedge clk);
    chk("rst_hold_busy", 64'(o_busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_empty = 1'b1; i_dt = '0; i_dnum = '0; i_start = 1'b0; i_base_adrs = '0;
    i_flush = 1'b0; i_ack = 1'b1; i_wack = 1'b1;
    #12 chk_outputs_zero();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();

    run_xfer(AW'(32'h100), 4, 0, 0, 1'b0);
    run_xfer(AW'(32'h100), 8, 0, 0, 1'b0);
    run_xfer(AW'(32'h200), 3, 0, 0, 1'b0);
    run_xfer(AW'(32'h300), 4, 1, 0, 1'b0);
    run_xfer(AW'((64'd1 << AW) - 64'd4), 8, 0, 0, 1'b0);
    mid_burst_reset();
    run_xfer(AW'(32'h40), 5, 0, 0, 1'b0);
    for (int k = 0; k < 20; k++)
      run_xfer(AW'($urandom), 1 + int'($urandom_range(0, 19)), 2, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter WIDTH, default 32, the data word width, matching the upstream FIFO.
REQ-002 Parameter RANGE, default 2, where the FIFO depth is 2^RANGE and the occupancy count is RANGE+1 bits wide.
REQ-003 Parameter BLEN, default 4, the full burst length in words; the legal range is 1..2^RANGE.
REQ-004 Parameter AW, default 30, the word-address width.
REQ-005 Port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port i_empty, input, 1 bit: FIFO empty flag.
REQ-008 Port i_dt, input, WIDTH bits: FIFO show-ahead read data.
REQ-009 Port i_dnum, input, RANGE+1 bits: FIFO occupancy.
REQ-010 Port o_renable, output, 1 bit: FIFO pop; one word is popped per cycle it is high.
REQ-011 Port i_start, input, 1 bit: single-cycle pulse that begins a transfer.
REQ-012 Port i_base_adrs, input, AW bits: start word address, sampled on i_start.
REQ-013 Port i_flush, input, 1 bit: level signal meaning the producer has finished; drain partial data and terminate.
REQ-014 Port o_req, output, 1 bit: burst command request.
REQ-015 Port o_adrs, output, AW bits: burst start address.
REQ-016 Port o_blen, output, RANGE+1 bits: burst length in words.
REQ-017 Port i_ack, input, 1 bit: command accepted.
REQ-018 Port o_wvalid, output, 1 bit: write data valid.
REQ-019 Port o_wdata, output, WIDTH bits: write data.
REQ-020 Port i_wack, input, 1 bit: write beat accepted.
REQ-021 Port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-022 Port o_done, output, 1 bit: single-cycle completion pulse.
REQ-023 Port o_wcount, output, 16 bits: number of words written since the last i_start.

Function
REQ-024 The state machine SHALL have exactly five states: IDLE, WAIT, CMD, DATA and DONE.
REQ-025 In IDLE, i_start SHALL load the address counter from i_base_adrs, clear o_wcount and enter WAIT on the next edge; i_start in any other state SHALL be ignored.
REQ-026 In WAIT, when i_dnum >= BLEN, the block SHALL latch blen = BLEN and enter CMD; this rule has priority over flush.
REQ-027 In WAIT, when i_flush=1, i_dnum < BLEN and i_empty=0, the block SHALL latch blen = i_dnum and enter CMD.
REQ-028 In WAIT, when i_flush=1 and i_empty=1, the block SHALL enter DONE.
REQ-029 In WAIT, in all other cases, the block SHALL remain in WAIT.
REQ-030 In CMD, o_req=1 and o_adrs/o_blen SHALL be driven from registers and held stable until i_ack; on i_ack the block SHALL clear the beat counter and enter DATA.
REQ-031 In DATA, o_wvalid SHALL be 1 and o_wdata SHALL equal i_dt combinationally (zero added latency).
REQ-032 In DATA, o_renable SHALL equal i_wack & !i_empty.
REQ-033 In DATA, each cycle with o_wvalid & i_wack SHALL increment the beat counter and o_wcount.
REQ-034 When the beat with index blen-1 is accepted, the block SHALL add blen to the address counter (wrapping modulo 2^AW) and return to WAIT.
REQ-035 If i_wack is low in DATA, o_wdata and the FIFO read pointer SHALL hold.
REQ-036 In DONE, o_done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE.
REQ-037 o_req SHALL be 0 outside CMD; o_wvalid and o_renable SHALL be 0 outside DATA.
REQ-038 o_wcount SHALL wrap from 0xFFFF to 0 with no flag.
REQ-039 The block SHALL never pop an empty FIFO and SHALL never issue a burst with blen = 0.
REQ-040 A change in i_dnum during DATA SHALL NOT alter the latched blen.
REQ-041 Dropping i_flush in WAIT SHALL return the block to threshold-only behaviour.
REQ-042 i_ack or i_wack asserted outside their respective states SHALL be ignored.

Reset
REQ-043 While rst=1, the block SHALL force state IDLE and drive o_renable, o_req, o_wvalid, o_busy and o_done to 0.
REQ-044 While rst=1, the block SHALL clear o_adrs, o_blen, o_wcount, the address counter and the beat counter to 0.
REQ-045 Reset asserted mid-burst SHALL abort immediately with no further pops; any words already popped are lost.

Verification
REQ-046 Basic burst: BLEN=4, i_start with base 0x100, 4 words pushed, i_ack and i_wack tied high -> o_req with o_adrs=0x100 and o_blen=4, then 4 beats with o_renable high for 4 cycles, o_wcount=4.
REQ-047 Back-to-back bursts: 8 words pushed -> two bursts at 0x100 and 0x104, each with o_blen=4; o_wcount=8.
REQ-048 Flush partial: 3 words pushed, then i_flush=1 -> burst with o_blen=3 and 3 beats, then o_done pulses once and o_busy falls the cycle after o_done.
REQ-049 Backpressure: i_wack toggled 1,0,1,0 -> o_wdata held during wack=0 cycles, 4 pops total, and o_wdata matches the push order exactly.
REQ-050 Address wrap: base 2^AW-4, 8 words -> bursts at 2^AW-4 and then at 0.
REQ-051 Mid-burst reset: assert rst after 2 beats -> all outputs are 0 and IDLE on the same cycle; a new i_start after release works normally from the given base address.
